// File: rtl/player_pkg.sv
// Shared types and constants for the player-side game stage.
package player_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    PENALTY = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'b00;
  localparam logic [1:0] WIN_PLAYER = 2'b01;
  localparam logic [1:0] WIN_PC     = 2'b10;
  localparam logic [1:0] WIN_TIE    = 2'b11;

endpackage

// File: rtl/player_stage_key_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge press pulse for one raw key.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  input  logic key_raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             settled;

  assign settled = (cnt == CNT_LAST);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      // synchroniser keeps sampling even while the counter is frozen
      sync_p0 <= key_raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      if (run) begin
        if (sync_p1 == level) begin
          cnt <= '0;
        end else if (settled) begin
          cnt   <= '0;
          level <= sync_p1;
          press <= sync_p1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/player_stage.sv
// Player game stage: debounced keys checked against the course pattern,
// BCD countdown of remaining boxes and race arbitration against the PC counter.
module player_stage
  import player_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int PENALTY_CYCLES  = 25000000,
  parameter int BOX_COUNT       = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             key_left,
  input  logic             key_right,
  input  logic [32:0]      loadval,
  input  logic             pc_ended,
  output logic [BCD_W-1:0] score_ones,
  output logic [BCD_W-1:0] score_tens,
  output logic             correct_pulse,
  output logic             wrong_pulse,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam int PEN_W = $clog2(PENALTY_CYCLES + 1);
  localparam logic [PEN_W-1:0] PEN_LOAD  = PEN_W'(PENALTY_CYCLES - 1);
  localparam logic [BCD_W-1:0] TENS_INIT = BCD_W'(BOX_COUNT / 10);
  localparam logic [BCD_W-1:0] ONES_INIT = BCD_W'(BOX_COUNT % 10);
  localparam logic [BCD_W-1:0] BCD_NINE  = BCD_W'(9);

  state_t           state;
  logic [32:0]      pattern;
  logic [PEN_W-1:0] pen_cnt;
  logic             run_keys;
  logic             press_left;
  logic             press_right;
  logic             active;
  logic             any_press;
  logic             hit;
  logic             score_last;
  logic             player_zero;

  // debouncers freeze together with the game while it is paused mid-play
  assign run_keys = enable || (state == IDLE) || (state == DONE);

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_left (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run_keys),
    .key_raw (key_left),
    .press   (press_left)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_right (
    .clock   (clock),
    .resetn  (resetn),
    .run     (run_keys),
    .key_raw (key_right),
    .press   (press_right)
  );

  assign active      = enable && (state == PLAY);
  assign any_press   = press_left || press_right;
  // exactly one key, and it names the side of the current box
  assign hit         = active && (press_left != press_right) && (press_right == pattern[0]);
  assign score_last  = (score_tens == '0) && (score_ones == BCD_W'(1));
  assign player_zero = hit && score_last;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state         <= IDLE;
      pattern       <= loadval;
      score_tens    <= TENS_INIT;
      score_ones    <= ONES_INIT;
      pen_cnt       <= '0;
      correct_pulse <= 1'b0;
      wrong_pulse   <= 1'b0;
      game_over     <= 1'b0;
      winner        <= WIN_NONE;
    end else begin
      correct_pulse <= 1'b0;
      wrong_pulse   <= 1'b0;
      if (!game_over && pc_ended && !player_zero) begin
        state     <= DONE;
        game_over <= 1'b1;
        winner    <= WIN_PC;
      end else begin
        case (state)
          IDLE: begin
            if (enable) state <= PLAY;
          end
          PLAY: begin
            if (hit) begin
              correct_pulse <= 1'b1;
              pattern       <= {1'b0, pattern[32:1]};
              if (score_ones == '0) begin
                score_ones <= BCD_NINE;
                score_tens <= score_tens - 1'b1;
              end else begin
                score_ones <= score_ones - 1'b1;
              end
              if (score_last) begin
                state     <= DONE;
                game_over <= 1'b1;
                winner    <= pc_ended ? WIN_TIE : WIN_PLAYER;
              end
            end else if (active && any_press) begin
              wrong_pulse <= 1'b1;
              pen_cnt     <= PEN_LOAD;
              state       <= PENALTY;
            end
          end
          PENALTY: begin
            if (enable) begin
              if (pen_cnt == '0) state <= PLAY;
              else               pen_cnt <= pen_cnt - 1'b1;
            end
          end
          DONE: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_player_stage.sv
// Randomised bench for player_stage against an event-level game model.
`timescale 1ns/1ps
module tb_player_stage;
  import player_pkg::*;

  localparam int DEB = 4;
  localparam int PEN = 8;
  localparam int BOX = 32;
  localparam int LAT = DEB + 3;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        enable = 1'b1;
  logic        key_left = 1'b0;
  logic        key_right = 1'b0;
  logic        pc_ended = 1'b0;
  logic [32:0] loadval = 33'h0_0000_0005;
  logic [3:0]  score_ones;
  logic [3:0]  score_tens;
  logic        correct_pulse;
  logic        wrong_pulse;
  logic        game_over;
  logic [1:0]  winner;

  always #5 clock = ~clock;

  player_stage #(
    .DEBOUNCE_CYCLES(DEB),
    .PENALTY_CYCLES (PEN),
    .BOX_COUNT      (BOX)
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .enable        (enable),
    .key_left      (key_left),
    .key_right     (key_right),
    .loadval       (loadval),
    .pc_ended      (pc_ended),
    .score_ones    (score_ones),
    .score_tens    (score_tens),
    .correct_pulse (correct_pulse),
    .wrong_pulse   (wrong_pulse),
    .game_over     (game_over),
    .winner        (winner)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ev_left[$];
  int ev_right[$];

  state_t      m_state;
  logic [32:0] m_pat;
  int          m_score;
  int          m_pen;
  bit          m_cp, m_wp, m_over;
  logic [1:0]  m_win;

  task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit pl, input bit pr);
    bit hit, last;
    if (!resetn) begin
      m_state = IDLE; m_pat = loadval; m_score = BOX; m_pen = 0;
      m_cp = 0; m_wp = 0; m_over = 0; m_win = WIN_NONE;
      ev_left.delete(); ev_right.delete();
      return;
    end
    m_cp = 0; m_wp = 0;
    hit  = (m_state == PLAY) && enable &&
           ((pl && !pr && m_pat[0] == 1'b0) || (pr && !pl && m_pat[0] == 1'b1));
    last = hit && (m_score == 1);
    if (!m_over && pc_ended && !last) begin
      m_over = 1; m_win = WIN_PC; m_state = DONE;
      return;
    end
    case (m_state)
      IDLE: if (enable) m_state = PLAY;
      PLAY: begin
        if (hit) begin
          m_cp = 1; m_pat = m_pat >> 1; m_score = m_score - 1;
          if (m_score == 0) begin
            m_state = DONE; m_over = 1;
            m_win = pc_ended ? WIN_TIE : WIN_PLAYER;
          end
        end else if (enable && (pl || pr)) begin
          m_wp = 1; m_pen = PEN - 1; m_state = PENALTY;
        end
      end
      PENALTY: if (enable) begin
        if (m_pen == 0) m_state = PLAY;
        else m_pen = m_pen - 1;
      end
      default: ;
    endcase
  endtask

  task automatic tick();
    bit pl, pr;
    @(posedge clock);
    cyc++;
    pl = 0; pr = 0;
    while (ev_left.size() > 0 && ev_left[0] <= cyc) begin
      pl = (ev_left[0] == cyc); void'(ev_left.pop_front());
    end
    while (ev_right.size() > 0 && ev_right[0] <= cyc) begin
      pr = (ev_right[0] == cyc); void'(ev_right.pop_front());
    end
    model_step(pl, pr);
    #1;
    check("score_tens", score_tens, m_score / 10);
    check("score_ones", score_ones, m_score % 10);
    check("correct_pulse", correct_pulse, m_cp);
    check("wrong_pulse", wrong_pulse, m_wp);
    check("game_over", game_over, m_over);
    check("winner", winner, m_win);
    check("state", dut.state, m_state);
  endtask

  // a clean rising edge yields a press event LAT edges later
  task automatic set_keys(input logic l, input logic r, input bit clean);
    if (clean && l && !key_left)  ev_left.push_back(cyc + LAT);
    if (clean && r && !key_right) ev_right.push_back(cyc + LAT);
    key_left = l; key_right = r;
  endtask

  task automatic press(input logic l, input logic r, input bit pc_at_event);
    set_keys(l, r, 1);
    repeat (DEB + 2) tick();
    if (pc_at_event) pc_ended = 1'b1;
    set_keys(0, 0, 0);
    repeat (DEB + 2) tick();
  endtask

  task automatic press_box(input bit correct);
    logic right;
    right = m_pat[0] ^ !correct;
    press(!right, right, 0);
  endtask

  task automatic do_reset(input logic [32:0] pat);
    pc_ended = 1'b0; enable = 1'b1;
    resetn = 1'b0; loadval = pat;
    repeat (2) tick();
    resetn = 1'b1;
    loadval = {1'($urandom_range(0, 1)), $urandom()};
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset, clean right press, then bounced left press
    do_reset(33'h0_0000_0005);
    check("rst_winner", winner, WIN_NONE);
    press(0, 1, 0);
    check("first_score", {score_tens, score_ones}, 8'h31);
    for (int i = 0; i < 20; i++) begin
      set_keys((i % 4) < 2, 0, 0);
      tick();
    end
    press(1, 0, 0);
    check("bounce_score", {score_tens, score_ones}, 8'h30);

    // wrong left press, overlapping right press lands inside the lockout
    set_keys(1, 0, 1); repeat (3) tick();
    set_keys(1, 1, 1); repeat (3) tick();
    set_keys(0, 1, 0); repeat (3) tick();
    set_keys(0, 0, 0); repeat (6) tick();
    check("pen_score", {score_tens, score_ones}, 8'h30);
    press(0, 1, 0);
    check("after_pen", {score_tens, score_ones}, 8'h29);
    press(1, 1, 0);
    repeat (PEN + 2) tick();

    // full game of correct presses with random pauses
    do_reset({1'($urandom_range(0, 1)), $urandom()});
    for (int i = 0; i < BOX; i++) begin
      press_box(1);
      if ($urandom_range(0, 3) == 0) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 5)) tick();
        enable = 1'b1;
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    check("player_win", winner, WIN_PLAYER);
    press_box(1);
    check("done_score", {score_tens, score_ones}, 8'h00);

    // PC finishes first at 17
    do_reset({1'($urandom_range(0, 1)), $urandom()});
    for (int i = 0; i < 15; i++) press_box(1);
    pc_ended = 1'b1;
    repeat (3) tick();
    press_box(1);
    check("pc_win", winner, WIN_PC);
    check("pc_score", {score_tens, score_ones}, 8'h17);

    // last press and pc_ended on the same edge
    do_reset({1'($urandom_range(0, 1)), $urandom()});
    for (int i = 0; i < BOX - 1; i++) press_box($urandom_range(0, 4) != 0);
    while (m_score > 1) press_box(1);
    begin
      logic right;
      right = m_pat[0];
      press(!right, right, 1);
    end
    check("tie", winner, WIN_TIE);

    // pause during the lockout
    do_reset({1'($urandom_range(0, 1)), $urandom()});
    press_box(0);
    enable = 1'b0;
    repeat (50) tick();
    enable = 1'b1;
    repeat (12) tick();
    press_box(1);
    for (int i = 0; i < 6; i++) press_box($urandom_range(0, 1));

    // reset in the middle of a lockout
    press_box(0);
    repeat (PEN + 12) tick();
    press_box(0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    check("midpen_rst", {game_over, winner, score_tens, score_ones}, 11'h032);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
